// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    // Hazard FSM states: normal issue, multi-cycle load-use bubble, data-memory freeze
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } hz_state_t;

    // Architectural register index
    typedef logic [4:0] regbits_t;

    // Forwarding select value meaning "operand comes from the register file"
    localparam int FWD_RF = 0;

endpackage

// File: rtl/hazard_ctrl_pipe_fwd_sel.sv
// Priority forwarding select for one EX operand: youngest writing stage wins, r0 never forwarded.
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever the inputs are.
module fwd_sel
    import cpu_types_pkg::*;
#(
    parameter int AW   = 5,
    parameter int NFWD = 2
) (
    input  logic [AW-1:0]              src_i,
    input  logic [NFWD-1:0]            regwrite_i,
    input  logic [NFWD*AW-1:0]         wsel_i,
    output logic [$clog2(NFWD+1)-1:0]  sel_o
);

    localparam int SELW = $clog2(NFWD + 1);

    // Scan oldest to youngest so the smallest matching stage index overwrites the rest
    always_comb begin
        sel_o = SELW'(FWD_RF);
        for (int k = NFWD; k >= 1; k--) begin
            if (regwrite_i[k-1] && (src_i != '0) && (wsel_i[(k-1)*AW +: AW] == src_i))
                sel_o = SELW'(k);
        end
    end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Hazard/forwarding controller: forwarding selects, pipeline enables/flushes, stall counter.
// Latency: selects, enables and flushes combinational; stall_cnt updates one cycle after a stall.
// Backpressure: a pending data access freezes every stage; load-use and ifetch miss hold the front end.
module hazard_ctrl_pipe #(
    parameter int AW       = 5,
    parameter int NFWD     = 2,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [AW-1:0]              rs_id,
    input  logic [AW-1:0]              rt_id,
    input  logic                       id_uses_rt,
    input  logic [AW-1:0]              rs_ex,
    input  logic [AW-1:0]              rt_ex,
    input  logic                       ex_memread,
    input  logic [AW-1:0]              ex_wsel,
    input  logic [NFWD-1:0]            stg_regwrite,
    input  logic [NFWD*AW-1:0]         stg_wsel,
    input  logic                       mem_dwen,
    input  logic [AW-1:0]              mem_rt,
    input  logic                       mem_req,
    input  logic                       dhit,
    input  logic                       ihit,
    input  logic                       redirect,
    input  logic                       perf_clr,
    output logic [$clog2(NFWD+1)-1:0]  fwd_a,
    output logic [$clog2(NFWD+1)-1:0]  fwd_b,
    output logic                       fwd_store,
    output logic                       pc_en,
    output logic                       ifid_en,
    output logic                       idex_en,
    output logic                       exmem_en,
    output logic                       memwb_en,
    output logic                       ifid_flush,
    output logic                       idex_flush,
    output logic [CW-1:0]              stall_cnt
);

    import cpu_types_pkg::*;

    localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

    hz_state_t        state_q, state_d;
    hz_state_t        resume_q, resume_d;
    hz_state_t        eff_state;
    logic [LCW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]    stall_cnt_q;
    logic             freeze;
    logic             load_use;

    fwd_sel #(.AW(AW), .NFWD(NFWD)) u_fwd_rs (
        .src_i      (rs_ex),
        .regwrite_i (stg_regwrite),
        .wsel_i     (stg_wsel),
        .sel_o      (fwd_a)
    );

    fwd_sel #(.AW(AW), .NFWD(NFWD)) u_fwd_rt (
        .src_i      (rt_ex),
        .regwrite_i (stg_regwrite),
        .wsel_i     (stg_wsel),
        .sel_o      (fwd_b)
    );

    // Store data in MEM comes from the oldest forwarding stage when it writes the store's rt
    assign fwd_store = mem_dwen && stg_regwrite[NFWD-1]
                    && (stg_wsel[(NFWD-1)*AW +: AW] != '0)
                    && (stg_wsel[(NFWD-1)*AW +: AW] == mem_rt);

    assign freeze   = mem_req && !dhit;
    assign load_use = ex_memread && (ex_wsel != '0)
                   && ((ex_wsel == rs_id) || (id_uses_rt && (ex_wsel == rt_id)));

    // While frozen, the state to resume into decides the pipeline behaviour on release
    assign eff_state = (state_q == MEMWAIT) ? resume_q : state_q;

    // FSM registers; reset aborts any stall or freeze in progress
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= RUN;
            resume_q <= RUN;
            ld_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    // Next state and pipeline controls: freeze > redirect > load-use > ifetch wait
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        ld_cnt_d   = ld_cnt_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (RST) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (freeze || ((state_q == MEMWAIT) && !dhit)) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            if (freeze && (state_q != MEMWAIT)) begin
                state_d  = MEMWAIT;
                resume_d = state_q;
            end
        end else begin
            case (eff_state)
                LDSTALL: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    if (state_q == LDSTALL) begin
                        ld_cnt_d = ld_cnt_q - LCW'(1);
                        if (ld_cnt_q == LCW'(1))
                            state_d = RUN;
                    end
                end
                default: begin
                    if (redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        if ((LOAD_LAT > 1) && (state_q == RUN)) begin
                            state_d  = LDSTALL;
                            ld_cnt_d = LCW'(LOAD_LAT - 1);
                        end
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
            endcase
            if (state_q == MEMWAIT)
                state_d = resume_q;
        end
    end

    // Saturating count of cycles in which the PC did not advance; clear has priority
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_cnt_q <= '0;
        else if (perf_clr)
            stall_cnt_q <= '0;
        else if (!pc_en && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CW'(1);
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Self-checking bench for hazard_ctrl_pipe (NFWD=2, LOAD_LAT=3, CW=4).
// Latency: outputs checked every cycle on the falling edge against a behavioural model.
// Backpressure: freeze, load-use, redirect and ifetch-wait scenarios driven directly.
module tb_hazard_ctrl_pipe;

    localparam int AW       = 5;
    localparam int NFWD     = 2;
    localparam int LOAD_LAT = 3;
    localparam int CW       = 4;
    localparam int SELW     = $clog2(NFWD + 1);
    localparam int SAT      = (1 << CW) - 1;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic [AW-1:0]       rs_id, rt_id, rs_ex, rt_ex, ex_wsel, mem_rt;
    logic                id_uses_rt, ex_memread, mem_dwen, mem_req, dhit, ihit, redirect, perf_clr;
    logic [NFWD-1:0]     stg_regwrite;
    logic [NFWD*AW-1:0]  stg_wsel;
    logic [SELW-1:0]     fwd_a, fwd_b;
    logic                fwd_store, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic                ifid_flush, idex_flush;
    logic [CW-1:0]       stall_cnt;

    hazard_ctrl_pipe #(.AW(AW), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .rs_id(rs_id), .rt_id(rt_id), .id_uses_rt(id_uses_rt),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
        .stg_regwrite(stg_regwrite), .stg_wsel(stg_wsel),
        .mem_dwen(mem_dwen), .mem_rt(mem_rt), .mem_req(mem_req),
        .dhit(dhit), .ihit(ihit), .redirect(redirect), .perf_clr(perf_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_store(fwd_store),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    int errs   = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // frozen: a data access is outstanding; bubbling: load bubbles still owed, owed: how many
    bit m_frozen, m_bubbling;
    int m_owed, m_stalls;

    function automatic bit is_load_use();
        return ex_memread && (ex_wsel != 0)
            && ((ex_wsel == rs_id) || (id_uses_rt && (ex_wsel == rt_id)));
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    function automatic logic [6:0] exp_ctrl();
        if (RST)                                       return 7'b0000000;
        if ((mem_req && !dhit) || (m_frozen && !dhit)) return 7'b0000000;
        if (m_bubbling)                                return 7'b0011101;
        if (redirect)                                  return 7'b1111111;
        if (is_load_use())                             return 7'b0011101;
        if (!ihit)                                     return 7'b0111110;
        return 7'b1111100;
    endfunction

    function automatic logic [SELW-1:0] exp_fwd(input logic [AW-1:0] r);
        if (r == 0) return '0;
        for (int k = 1; k <= NFWD; k++)
            if (stg_regwrite[k-1] && (stg_wsel[(k-1)*AW +: AW] == r)) return SELW'(k);
        return '0;
    endfunction

    function automatic logic exp_store();
        logic [AW-1:0] w;
        w = stg_wsel[(NFWD-1)*AW +: AW];
        return mem_dwen && stg_regwrite[NFWD-1] && (w != 0) && (w == mem_rt);
    endfunction

    always @(posedge CLK or posedge RST) begin
        logic [6:0] e;
        if (RST) begin
            m_frozen = 0; m_bubbling = 0; m_owed = 0; m_stalls = 0;
        end else begin
            e = exp_ctrl();
            if (perf_clr)                        m_stalls = 0;
            else if (!e[6] && m_stalls < SAT)    m_stalls = m_stalls + 1;
            if (mem_req && !dhit)                m_frozen = 1;
            else if (m_frozen) begin
                if (dhit) m_frozen = 0;
            end else if (m_bubbling) begin
                m_owed = m_owed - 1;
                if (m_owed == 0) m_bubbling = 0;
            end else if (!redirect && is_load_use() && LOAD_LAT > 1) begin
                m_bubbling = 1;
                m_owed     = LOAD_LAT - 1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge CLK) begin
        if (check_en) begin
            chk("ctrl", {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush},
                {25'd0, exp_ctrl()});
            chk("fwd_a", 32'(fwd_a), 32'(exp_fwd(rs_ex)));
            chk("fwd_b", 32'(fwd_b), 32'(exp_fwd(rt_ex)));
            chk("fwd_store", 32'(fwd_store), 32'(exp_store()));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
            if (!RST && m_bubbling && !m_frozen && redirect) begin
                checks++; errs++;
                $display("FAIL redirect_in_ldstall: got 1 expected 0 at %0t", $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rs_id = 0; rt_id = 0; id_uses_rt = 0; rs_ex = 0; rt_ex = 0;
        ex_memread = 0; ex_wsel = 0; stg_regwrite = 0; stg_wsel = 0;
        mem_dwen = 0; mem_rt = 0; mem_req = 0; dhit = 1; ihit = 1;
        redirect = 0; perf_clr = 0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic mid();
        @(negedge CLK); #2;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_wsel = 5'd8; rs_id = 5'd8;
    endtask

    initial begin
        idle();
        #1 RST = 1;
        check_en = 1;
        tick(); tick();
        mid();
        chk("lit_reset_pc_en", 32'(pc_en), 32'd0);
        chk("lit_reset_stall", 32'(stall_cnt), 32'd0);
        tick();
        RST = 0;

        // forwarding: youngest stage wins, r0 never forwarded
        stg_regwrite = 2'b11; stg_wsel = {5'd5, 5'd5}; rs_ex = 5'd5; rt_ex = 5'd5;
        mid(); chk("lit_fwd_youngest", 32'(fwd_a), 32'd1);
        tick();
        stg_wsel = {5'd7, 5'd0}; rs_ex = 5'd0; rt_ex = 5'd7;
        mid(); chk("lit_fwd_r0", 32'(fwd_a), 32'd0);
        chk("lit_fwd_stg2", 32'(fwd_b), 32'd2);
        tick();
        stg_regwrite = 2'b10; stg_wsel = {5'd4, 5'd4}; rs_ex = 5'd4; rt_ex = 5'd3;
        tick();

        // store-data forwarding
        mem_dwen = 1; mem_rt = 5'd9; stg_regwrite = 2'b10; stg_wsel = {5'd9, 5'd3};
        mid(); chk("lit_store_fwd", 32'(fwd_store), 32'd1);
        tick();
        stg_wsel = {5'd0, 5'd3}; mem_rt = 5'd0;
        mid(); chk("lit_store_r0", 32'(fwd_store), 32'd0);
        tick();
        idle();

        // load-use with LOAD_LAT=3: three stall cycles then RUN
        set_load_use();
        mid(); chk("lit_lu_pc_en", 32'(pc_en), 32'd0);
        chk("lit_lu_idex_flush", 32'(idex_flush), 32'd1);
        tick(); idle();
        mid(); chk("lit_ld1_pc_en", 32'(pc_en), 32'd0);
        tick();
        mid(); chk("lit_ld2_pc_en", 32'(pc_en), 32'd0);
        tick();
        mid(); chk("lit_ld_done_pc_en", 32'(pc_en), 32'd1);
        chk("lit_ld_done_stall", 32'(stall_cnt), 32'd3);
        tick();

        // freeze in LDSTALL with one bubble left, then resume the stall
        set_load_use();
        tick(); idle();
        tick();
        mem_req = 1; dhit = 0;
        mid(); chk("lit_frz_pc_en", 32'(pc_en), 32'd0);
        chk("lit_frz_memwb_en", 32'(memwb_en), 32'd0);
        repeat (4) tick();
        dhit = 1;
        mid(); chk("lit_rel_idex_flush", 32'(idex_flush), 32'd1);
        chk("lit_rel_exmem_en", 32'(exmem_en), 32'd1);
        tick();
        mem_req = 0;
        mid(); chk("lit_last_bubble", 32'(pc_en), 32'd0);
        tick();
        mid(); chk("lit_after_frz_pc_en", 32'(pc_en), 32'd1);
        chk("lit_after_frz_stall", 32'(stall_cnt), 32'd11);
        tick();

        // redirect beats load-use; state stays RUN
        set_load_use(); redirect = 1;
        mid(); chk("lit_redir_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("lit_redir_idex_flush", 32'(idex_flush), 32'd1);
        chk("lit_redir_pc_en", 32'(pc_en), 32'd1);
        tick(); idle();
        mid(); chk("lit_redir_run", 32'(pc_en), 32'd1);
        tick();

        // ifetch wait
        ihit = 0;
        mid(); chk("lit_ifw_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("lit_ifw_idex_en", 32'(idex_en), 32'd1);
        tick();

        // freeze from RUN, resume into RUN
        ihit = 1; mem_req = 1; dhit = 0;
        repeat (2) tick();
        dhit = 1;
        tick(); idle();

        // perf_clr wins over increment
        ihit = 0; perf_clr = 1;
        tick();
        perf_clr = 0; ihit = 1;
        mid(); chk("lit_perf_clr", 32'(stall_cnt), 32'd0);
        tick();

        // saturation at 2**CW-1
        ihit = 0;
        repeat (20) tick();
        ihit = 1;
        mid(); chk("lit_saturate", 32'(stall_cnt), 32'(SAT));
        tick();

        // reset in the middle of MEMWAIT
        mem_req = 1; dhit = 0;
        repeat (2) tick();
        #2 RST = 1;
        #1 chk("lit_rst_stall", 32'(stall_cnt), 32'd0);
        chk("lit_rst_pc_en", 32'(pc_en), 32'd0);
        tick();
        RST = 0; mem_req = 0; dhit = 0;
        mid(); chk("lit_rst_run", 32'(pc_en), 32'd1);
        tick();
        idle();
        repeat (3) tick();

        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
